// File: rtl/uart_tx_async_if.sv
// uart_tx_async_if
// Byte-side handshake between the byte source and the UART transmitter.
//   tx_data       byte to send (holding-register input or FIFO read data)
//   write_tx_data one-clk load strobe (holding-register mode)
//   fifo_empty    external FIFO empty (FIFO mode)
//   fifo_read_n   active-low one-clk FIFO pop from the transmitter
//   tx_ready      holding register empty
//   tx_busy       frame in progress
//   tx_done       one-clk pulse at the end of the stop bit
// master = byte source side, slave = transmitter side.
interface uart_tx_async_if;
    logic [7:0] tx_data;
    logic       write_tx_data;
    logic       fifo_empty;
    logic       fifo_read_n;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, write_tx_data, fifo_empty,
        input  fifo_read_n, tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, write_tx_data, fifo_empty,
        output fifo_read_n, tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_async.sv
// uart_tx_async
// Serial transmitter: start bit, 7/8 data bits LSB first, optional parity,
// one stop bit. Bit timing is 16 baud_clock enables per bit.
//   TX_FIFO       0 = bytes from write_tx_data strobe, 1 = pulled from FIFO
//   clk, reset_n  system clock, asynchronous active-low reset
//   baud_clock_i  one-clk enable at 16x bit rate
//   bit8_i        1 = 8 data bits, 0 = 7 data bits
//   parity_en_i   1 = append parity bit
//   odd_n_even_i  1 = odd parity, 0 = even parity
//   bus           byte handshake (slave side)
//   tx_o          serial output, idle high
module uart_tx_async #(
    parameter bit TX_FIFO = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         baud_clock_i,
    input  logic         bit8_i,
    input  logic         parity_en_i,
    input  logic         odd_n_even_i,
    uart_tx_async_if.slave bus,
    output logic         tx_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] hold_q;
    logic       hold_full_q;
    logic [7:0] shift_q;
    logic [3:0] bit_cnt_q;
    logic [3:0] sub_cnt_q;
    logic       par_q;
    logic       bit8_q;
    logic       par_en_q;
    logic       odd_q;
    logic       tx_q;
    logic       done_q;
    logic       rd_q;   // pop strobe is on fifo_read_n this clk
    logic       cap_q;  // popped byte is on tx_data this clk

    logic       sub_last;
    logic       load;
    logic [3:0] last_bit;

    assign sub_last = (sub_cnt_q == 4'hF);
    assign last_bit = bit8_q ? 4'd7 : 4'd6;
    // Shift stage takes the held byte from IDLE or straight out of the
    // final stop-bit tick, so consecutive frames have no gap.
    assign load = baud_clock_i && hold_full_q &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && sub_last));

    // Holding register. A transfer into the shift stage always wins over a
    // same-clk write, which is ignored because tx_ready was low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rd_q        <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            rd_q  <= 1'b0;
            cap_q <= rd_q;
            if (TX_FIFO) begin
                if (cap_q) begin
                    hold_q      <= bus.tx_data;
                    hold_full_q <= 1'b1;
                end else if (load) begin
                    hold_full_q <= 1'b0;
                end
                // One pop at a time: wait until the previous byte landed.
                if (!hold_full_q && !bus.fifo_empty && !rd_q && !cap_q)
                    rd_q <= 1'b1;
            end else begin
                if (load) begin
                    hold_full_q <= 1'b0;
                end else if (bus.write_tx_data && !hold_full_q) begin
                    hold_q      <= bus.tx_data;
                    hold_full_q <= 1'b1;
                end
            end
        end
    end

    // Frame state machine; tx is registered and set for the state entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            sub_cnt_q <= 4'd0;
            par_q     <= 1'b0;
            bit8_q    <= 1'b0;
            par_en_q  <= 1'b0;
            odd_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (baud_clock_i) begin
                if (state_q != S_IDLE)
                    sub_cnt_q <= sub_cnt_q + 4'd1;
                case (state_q)
                    S_IDLE: begin
                        tx_q <= 1'b1;
                    end
                    S_START: begin
                        if (sub_last) begin
                            state_q <= S_DATA;
                            tx_q    <= shift_q[0];
                        end
                    end
                    S_DATA: begin
                        if (sub_last) begin
                            par_q     <= par_q ^ shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == last_bit) begin
                                if (par_en_q) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_q ^ shift_q[0] ^ odd_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                tx_q <= shift_q[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (sub_last) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (sub_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        sub_cnt_q <= 4'd0;
                        tx_q      <= 1'b1;
                    end
                endcase
                // Overrides the IDLE/STOP outcome above when a byte is waiting.
                if (load) begin
                    shift_q   <= hold_q;
                    bit8_q    <= bit8_i;
                    par_en_q  <= parity_en_i;
                    odd_q     <= odd_n_even_i;
                    sub_cnt_q <= 4'd0;
                    bit_cnt_q <= 4'd0;
                    par_q     <= 1'b0;
                    state_q   <= S_START;
                    tx_q      <= 1'b0;
                end
            end
        end
    end

    assign tx_o            = tx_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.tx_busy     = (state_q != S_IDLE);
    assign bus.tx_done     = done_q;
    assign bus.fifo_read_n = ~rd_q;

endmodule

// File: tb/tb_uart_tx_async.sv
module tb_uart_tx_async;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic baud_clock = 1'b0;
    bit   baud_en = 1'b1;
    logic bit8 = 1'b1;
    logic parity_en = 1'b0;
    logic odd_n_even = 1'b0;
    logic tx0;
    logic tx1;

    int checks = 0;
    int failures = 0;

    // External FIFO model for the TX_FIFO=1 instance.
    logic [7:0] fq[$];
    logic [7:0] f_data = 8'h00;
    logic       f_empty = 1'b1;
    int         pops = 0;

    uart_tx_async_if if0 ();
    uart_tx_async_if if1 ();

    uart_tx_async #(.TX_FIFO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clock_i(baud_clock),
        .bit8_i(bit8), .parity_en_i(parity_en), .odd_n_even_i(odd_n_even),
        .bus(if0.slave), .tx_o(tx0)
    );

    uart_tx_async #(.TX_FIFO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clock_i(baud_clock),
        .bit8_i(bit8), .parity_en_i(parity_en), .odd_n_even_i(odd_n_even),
        .bus(if1.slave), .tx_o(tx1)
    );

    assign if0.fifo_empty    = 1'b1;
    assign if1.tx_data       = f_data;
    assign if1.fifo_empty    = f_empty;
    assign if1.write_tx_data = 1'b0;

    always #5 clk = ~clk;

    // Random baud enables (about 3 in 4 clks), changed just after each edge.
    always @(posedge clk) begin
        #1;
        baud_clock = baud_en ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    // Read data appears on the clk after the pop strobe.
    always @(posedge clk) begin
        if (if1.fifo_read_n == 1'b0) begin
            pops <= pops + 1;
            if (fq.size() > 0) f_data <= fq.pop_front();
        end
        f_empty <= (fq.size() == 0);
    end

    function automatic logic get_tx(input bit s);
        return s ? tx1 : tx0;
    endfunction
    function automatic logic get_rdy(input bit s);
        return s ? if1.tx_ready : if0.tx_ready;
    endfunction
    function automatic logic get_busy(input bit s);
        return s ? if1.tx_busy : if0.tx_busy;
    endfunction
    function automatic logic get_done(input bit s);
        return s ? if1.tx_done : if0.tx_done;
    endfunction

    task automatic set_cfg(input bit b8, input bit pe, input bit od);
        bit8 = b8; parity_en = pe; odd_n_even = od;
    endtask

    task automatic write0(input logic [7:0] b, input bit chk);
        @(posedge clk); #2;
        if0.tx_data = b;
        if0.write_tx_data = 1'b1;
        @(posedge clk); #2;
        if0.write_tx_data = 1'b0;
        if (chk) begin
            checks++;
            if (if0.tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_ready: tx_ready=%b expected 0", if0.tx_ready);
            end
        end
    endtask

    // Reference frame: expected line level per bit period, from the byte and
    // config alone; checked at every negedge, advancing one bit per 16 pulses.
    task automatic frame(input bit s, input logic [7:0] b, input bit b8, input bit pe,
                         input bit od, input bit wait_start, input bit nxt, input string nm);
        bit   bits[$];
        bit   par;
        int   n, total, k, cyc, w, bad_k;
        bit   bad;
        logic bad_v;
        bit   exp_v;
        n = b8 ? 8 : 7;
        par = od;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(b[i]);
            par = par ^ b[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        total = 16 * bits.size();
        if (wait_start) begin
            w = 0;
            @(negedge clk);
            while (get_tx(s) !== 1'b0 && w < 4000) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (get_tx(s) !== 1'b0) begin
                failures++;
                $display("FAIL %s_start: tx=%b never went low", nm, get_tx(s));
                return;
            end
        end
        checks++;
        if (get_rdy(s) !== 1'b1 || get_busy(s) !== 1'b1) begin
            failures++;
            $display("FAIL %s_start_flags: ready=%b busy=%b expected 1 1", nm, get_rdy(s), get_busy(s));
        end
        k = 0; cyc = 0; bad = 0; bad_k = 0; bad_v = 1'b0; exp_v = 1'b0;
        while (k < total && cyc < total * 8 + 400) begin
            if (!bad && (get_tx(s) !== bits[k / 16] || get_busy(s) !== 1'b1 ||
                         (cyc > 0 && get_done(s) !== 1'b0))) begin
                bad = 1; bad_k = k; bad_v = get_tx(s); exp_v = bits[k / 16];
            end
            if (baud_clock) k++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (k < total) begin
            failures++;
            $display("FAIL %s_len: only %0d of %0d pulses counted", nm, k, total);
            return;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_bits: pulse %0d tx=%b expected %b (or busy/done wrong)", nm, bad_k, bad_v, exp_v);
        end
        checks++;
        if (get_done(s) !== 1'b1 || get_tx(s) !== !nxt || get_busy(s) !== nxt) begin
            failures++;
            $display("FAIL %s_end: done=%b tx=%b busy=%b expected 1 %b %b",
                     nm, get_done(s), get_tx(s), get_busy(s), !nxt, nxt);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_busy !== 1'b0 ||
            if0.tx_done !== 1'b0 || if0.fifo_read_n !== 1'b1) begin
            failures++;
            $display("FAIL reset0: tx=%b rdy=%b busy=%b done=%b rdn=%b expected 1 1 0 0 1",
                     tx0, if0.tx_ready, if0.tx_busy, if0.tx_done, if0.fifo_read_n);
        end
        checks++;
        if (tx1 !== 1'b1 || if1.tx_ready !== 1'b1 || if1.tx_busy !== 1'b0 ||
            if1.tx_done !== 1'b0 || if1.fifo_read_n !== 1'b1) begin
            failures++;
            $display("FAIL reset1: tx=%b rdy=%b busy=%b done=%b rdn=%b expected 1 1 0 0 1",
                     tx1, if1.tx_ready, if1.tx_busy, if1.tx_done, if1.fifo_read_n);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed();
        set_cfg(1, 0, 0); write0(8'hA5, 1); frame(0, 8'hA5, 1, 0, 0, 1, 0, "8n1_a5");
        set_cfg(1, 1, 0); write0(8'h07, 1); frame(0, 8'h07, 1, 1, 0, 1, 0, "8e1_07");
        set_cfg(0, 1, 1); write0(8'h85, 1); frame(0, 8'h85, 0, 1, 1, 1, 0, "7o1_85");
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit b8, pe, od;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom); b8 = 1'($urandom); pe = 1'($urandom); od = 1'($urandom);
            set_cfg(b8, pe, od);
            write0(b, 1);
            frame(0, b, b8, pe, od, 1, 0, "rand");
        end
    endtask

    task automatic test_back_to_back();
        int w;
        set_cfg(1, 0, 0);
        fork
            begin
                write0(8'h55, 1);
                w = 0;
                while (if0.tx_ready !== 1'b1 && w < 4000) begin
                    @(negedge clk);
                    w++;
                end
                write0(8'hAA, 1);
                repeat (5) @(negedge clk);
                write0(8'h33, 0);
            end
            begin
                frame(0, 8'h55, 1, 0, 0, 1, 1, "b2b_55");
                frame(0, 8'hAA, 1, 0, 0, 0, 0, "b2b_aa");
            end
        join
        repeat (100) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: tx=%b busy=%b rdy=%b expected 1 0 1", tx0, if0.tx_busy, if0.tx_ready);
        end
    endtask

    task automatic test_cfg_latch();
        logic [7:0] b;
        b = 8'($urandom);
        set_cfg(1, 1, 1);
        write0(b, 1);
        fork
            frame(0, b, 1, 1, 1, 1, 0, "cfg_latch");
            begin
                repeat (100) @(negedge clk);
                set_cfg(0, 0, 0);
            end
        join
        set_cfg(1, 0, 0);
    endtask

    task automatic test_freeze();
        logic [7:0] b;
        logic t, bz;
        b = 8'($urandom);
        set_cfg(1, 0, 0);
        baud_en = 0;
        repeat (2) @(negedge clk);
        write0(b, 1);
        repeat (40) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL freeze_idle: tx=%b busy=%b rdy=%b expected 1 0 0", tx0, if0.tx_busy, if0.tx_ready);
        end
        baud_en = 1;
        fork
            frame(0, b, 1, 0, 0, 1, 0, "freeze");
            begin
                repeat (150) @(negedge clk);
                baud_en = 0;
                repeat (2) @(negedge clk);
                t = tx0; bz = if0.tx_busy;
                repeat (50) @(negedge clk);
                checks++;
                if (tx0 !== t || if0.tx_busy !== bz || bz !== 1'b1) begin
                    failures++;
                    $display("FAIL freeze_mid: tx=%b busy=%b expected %b 1", tx0, if0.tx_busy, t);
                end
                baud_en = 1;
            end
        join
    endtask

    task automatic test_fifo();
        int p0;
        set_cfg(1, 0, 0);
        p0 = pops;
        @(negedge clk);
        fq.push_back(8'h31);
        fq.push_back(8'h32);
        frame(1, 8'h31, 1, 0, 0, 1, 1, "fifo_31");
        frame(1, 8'h32, 1, 0, 0, 0, 0, "fifo_32");
        repeat (20) @(negedge clk);
        checks++;
        if (pops - p0 !== 2) begin
            failures++;
            $display("FAIL fifo_pops: pops=%0d expected 2", pops - p0);
        end
        checks++;
        if (tx1 !== 1'b1 || if1.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL fifo_idle: tx=%b busy=%b expected 1 0", tx1, if1.tx_busy);
        end
    endtask

    task automatic test_mid_reset();
        int   k, w;
        bit   wrote;
        logic [7:0] b;
        set_cfg(1, 0, 0);
        write0(8'hA5, 1);
        w = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        k = 0; wrote = 0; w = 0;
        // Stop mid DATA bit 3 (bit period 4); a second byte sits in hold.
        while (k < 72 && w < 2000) begin
            if (if0.write_tx_data) if0.write_tx_data = 1'b0;
            if (!wrote && k >= 2) begin
                if0.tx_data = 8'h3C;
                if0.write_tx_data = 1'b1;
                wrote = 1;
            end
            if (baud_clock) k++;
            w++;
            @(negedge clk);
        end
        if0.write_tx_data = 1'b0;
        checks++;
        if (tx0 !== 1'b0 || if0.tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre: tx=%b rdy=%b expected 0 0", tx0, if0.tx_ready);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: tx=%b rdy=%b busy=%b expected 1 1 0", tx0, if0.tx_ready, if0.tx_busy);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || if0.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard: tx=%b busy=%b expected 1 0", tx0, if0.tx_busy);
        end
        b = 8'($urandom);
        write0(b, 1);
        frame(0, b, 1, 0, 0, 1, 0, "rst_after");
    endtask

    initial begin
        if0.tx_data = 8'h00;
        if0.write_tx_data = 1'b0;
        test_reset();
        test_fixed();
        test_random();
        test_back_to_back();
        test_cfg_latch();
        test_freeze();
        test_fifo();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
